// File: rtl/rvc_asap_5pl_vga_ctrl.sv
// VGA raster controller for the 5-stage core: 640x480@60 timing,
// 1bpp bitmap fetch over memory port B, 4:4:4 colour and sync out.
module rvc_asap_5pl_vga_ctrl #(
    parameter int H_VISIBLE      = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BP           = 48,
    parameter int V_VISIBLE      = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 33,
    parameter int WORDS_PER_LINE = 20
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        cfg_en,
    input  logic [11:0] cfg_fg,
    input  logic [11:0] cfg_bg,
    input  logic [8:0]  cfg_scroll,
    output logic [13:0] address_b,
    input  logic [31:0] q_b,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vblank_pulse,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        frame_end;

    logic        en_q;
    logic [11:0] fg_q, bg_q;
    logic [8:0]  scroll_q, scroll_d;
    logic [15:0] frame_cnt_q;

    logic [9:0]  line_sum, line;
    logic [13:0] line_ext, line_mul;
    logic        vis_s0, hs_s0, vs_s0, vb_s0;

    logic        vis1_q, hs1_q, vs1_q, vb1_q;
    logic [4:0]  px1_q;

    logic [11:0] rgb_d, rgb_q;
    logic        hs_q, vs_q, vb_q;

    assign frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

    // Raster position advance: h every clock, v at end of each line
    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 10'd0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    // Raster position registers
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= 10'd0;
            v_cnt_q <= 10'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Out-of-range scroll values collapse to no scroll
    assign scroll_d = ({1'b0, cfg_scroll} >= V_VIS) ? 9'd0 : cfg_scroll;

    // Config shadows and frame counter update only at the frame wrap
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            en_q        <= 1'b0;
            fg_q        <= 12'h000;
            bg_q        <= 12'h000;
            scroll_q    <= 9'd0;
            frame_cnt_q <= 16'd0;
        end else if (frame_end) begin
            en_q        <= cfg_en;
            fg_q        <= cfg_fg;
            bg_q        <= cfg_bg;
            scroll_q    <= scroll_d;
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign line_sum = v_cnt_q + {1'b0, scroll_q};
    assign line     = (line_sum >= V_VIS) ? line_sum - V_VIS : line_sum;
    assign line_ext = {4'd0, line};

    if (WORDS_PER_LINE == 20) begin : g_shift
        assign line_mul = (line_ext << 4) + (line_ext << 2);
    end else begin : g_mul
        assign line_mul = line_ext * 14'(WORDS_PER_LINE);
    end

    assign vis_s0 = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign hs_s0  = (h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END);
    assign vs_s0  = (v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END);
    assign vb_s0  = (h_cnt_q == 10'd0) && (v_cnt_q == V_VIS);

    // Blanking drives address 0 to keep the fetch in range
    assign address_b = vis_s0 ? line_mul + {9'd0, h_cnt_q[9:5]} : 14'd0;

    // Stage 1: delay flags and pixel index to line up with q_b
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vis1_q <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            vb1_q  <= 1'b0;
            px1_q  <= 5'd0;
        end else begin
            vis1_q <= vis_s0;
            hs1_q  <= hs_s0;
            vs1_q  <= vs_s0;
            vb1_q  <= vb_s0;
            px1_q  <= h_cnt_q[4:0];
        end
    end

    // Bit 0 of each fetched word is the leftmost pixel
    always_comb begin
        rgb_d = 12'h000;
        if (vis1_q && en_q) begin
            rgb_d = q_b[px1_q] ? fg_q : bg_q;
        end
    end

    // Stage 2: registered pixel colour, active-low syncs, vblank event
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= 12'h000;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            vb_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= ~hs1_q;
            vs_q  <= ~vs1_q;
            vb_q  <= vb1_q;
        end
    end

    assign vga_r        = rgb_q[11:8];
    assign vga_g        = rgb_q[7:4];
    assign vga_b        = rgb_q[3:0];
    assign vga_hs       = hs_q;
    assign vga_vs       = vs_q;
    assign vblank_pulse = vb_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_rvc_asap_5pl_vga_ctrl.sv
// Directed bench for the VGA controller with a shortened vertical
// geometry (6 visible lines, 10 total) and full 800-clock lines.
module tb_rvc_asap_5pl_vga_ctrl;

    localparam int HV  = 640;
    localparam int HT  = 800;
    localparam int VV  = 6;
    localparam int VT  = 10;
    localparam int FRM = HT * VT;

    logic        clock;
    logic        rst_n;
    logic        cfg_en;
    logic [11:0] cfg_fg, cfg_bg;
    logic [8:0]  cfg_scroll;
    logic [13:0] address_b;
    logic [31:0] q_b;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vblank_pulse;
    logic [15:0] frame_cnt;

    rvc_asap_5pl_vga_ctrl #(
        .H_VISIBLE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_VISIBLE(VV), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .WORDS_PER_LINE(20)
    ) dut (
        .clock(clock), .rst_n(rst_n),
        .cfg_en(cfg_en), .cfg_fg(cfg_fg), .cfg_bg(cfg_bg),
        .cfg_scroll(cfg_scroll),
        .address_b(address_b), .q_b(q_b),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vblank_pulse(vblank_pulse), .frame_cnt(frame_cnt)
    );

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
        logic        vb;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    logic [31:0] mem [0:127];
    int th, tv;

    initial clock = 1'b0;
    always #20 clock = ~clock;

    // port B memory model: one-cycle synchronous read
    always @(posedge clock) q_b <= mem[address_b[6:0]];

    // reference raster position
    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            th <= 0;
            tv <= 0;
        end else if (th == HT - 1) begin
            th <= 0;
            tv <= (tv == VT - 1) ? 0 : tv + 1;
        end else begin
            th <= th + 1;
        end
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic goto(int h, int v);
        int n = 0;
        while (!(th == h && tv == v) && n < 20000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20000) begin
            n_tests++;
            n_fail++;
            $error("FAIL goto(%0d,%0d): timeout", h, v);
        end
    endtask

    task automatic push(string tag, logic [11:0] rgb,
                        logic hs, logic vs, logic vb);
        exp_t e;
        e.rgb = rgb;
        e.hs  = hs;
        e.vs  = vs;
        e.vb  = vb;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic pop_chk();
        exp_t  e;
        string t;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL scoreboard: empty");
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, ".rgb"}, {20'd0, vga_r, vga_g, vga_b}, {20'd0, e.rgb});
        chk({t, ".hs"}, {31'd0, vga_hs}, {31'd0, e.hs});
        chk({t, ".vs"}, {31'd0, vga_vs}, {31'd0, e.vs});
        chk({t, ".vb"}, {31'd0, vblank_pulse}, {31'd0, e.vb});
    endtask

    task automatic pix(string tag, logic [11:0] rgb,
                       logic hs, logic vs);
        push(tag, rgb, hs, vs, 1'b0);
        repeat (2) @(negedge clock);
        pop_chk();
    endtask

    task automatic chk_reset(string tag);
        chk({tag, ".rgb"}, {20'd0, vga_r, vga_g, vga_b}, 32'd0);
        chk({tag, ".hs"}, {31'd0, vga_hs}, 32'd1);
        chk({tag, ".vs"}, {31'd0, vga_vs}, 32'd1);
        chk({tag, ".vb"}, {31'd0, vblank_pulse}, 32'd0);
        chk({tag, ".addr"}, {18'd0, address_b}, 32'd0);
        chk({tag, ".fcnt"}, {16'd0, frame_cnt}, 32'd0);
    endtask

    initial begin
        int hs_lo, hs_l0, hs_first, vs_lo, vb_n, vb_at;
        logic [31:0] w0;

        for (int i = 0; i < 128; i++) mem[i] = 32'h8000_0001;
        w0 = 32'h0000_0005;
        mem[0] = w0;

        rst_n      = 1'b1;
        cfg_en     = 1'b1;
        cfg_fg     = 12'hF00;
        cfg_bg     = 12'h00F;
        cfg_scroll = 9'd0;
        #5 rst_n = 1'b0;
        #1 chk_reset("por");
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b1;

        // frame 0: shadows still disabled
        pix("f0_black", 12'h000, 1'b1, 1'b1);
        goto(32, 1);
        chk("addr_32_1", {18'd0, address_b}, 32'd21);
        goto(639, VV - 1);
        chk("addr_last", {18'd0, address_b}, 32'd119);
        goto(700, VV - 1);
        chk("addr_hblank", {18'd0, address_b}, 32'd0);
        goto(0, VV + 1);
        chk("addr_vblank", {18'd0, address_b}, 32'd0);

        // frame 1: pixel mapping of word 0 on line 0
        goto(0, 0);
        chk("fcnt1", {16'd0, frame_cnt}, 32'd1);
        for (int i = 0; i < 34; i++) begin
            if (i < 32)
                push($sformatf("px%0d", i),
                     w0[i] ? 12'hF00 : 12'h00F, 1'b1, 1'b1, 1'b0);
            if (i >= 2) pop_chk();
            @(negedge clock);
        end

        // frame 2: sync and vblank timing over one whole frame
        goto(0, 0);
        chk("fcnt2", {16'd0, frame_cnt}, 32'd2);
        hs_lo = 0; hs_l0 = 0; hs_first = -1;
        vs_lo = 0; vb_n = 0; vb_at = -1;
        for (int i = 0; i < FRM; i++) begin
            if (!vga_hs) begin
                hs_lo++;
                if (i < HT) hs_l0++;
                if (hs_first < 0) hs_first = i;
            end
            if (!vga_vs) vs_lo++;
            if (vblank_pulse) begin
                vb_n++;
                vb_at = i;
            end
            @(negedge clock);
        end
        chk("hs_first", hs_first, 32'd658);
        chk("hs_line_len", hs_l0, 32'd96);
        chk("hs_frame_tot", hs_lo, 32'(96 * VT));
        chk("vs_low_len", vs_lo, 32'd1600);
        chk("vb_count", vb_n, 32'd1);
        chk("vb_pos", vb_at, 32'(VV * HT + 2));

        // frame 3: mid-frame config changes stay invisible
        cfg_scroll = 9'd2;
        goto(100, 2);
        cfg_fg = 12'h0F0;
        goto(0, 3);
        pix("f3_old_fg", 12'hF00, 1'b1, 1'b1);
        goto(0, 4);
        chk("addr_noscroll", {18'd0, address_b}, 32'd80);

        // frame 4: new fg and scroll 2 take effect
        goto(0, 0);
        pix("f4_new_fg", 12'h0F0, 1'b1, 1'b1);
        goto(0, 3);
        chk("addr_scr_l5", {18'd0, address_b}, 32'd100);
        pix("f4_scr_px", 12'h0F0, 1'b1, 1'b1);
        goto(0, 4);
        chk("addr_scr_wrap", {18'd0, address_b}, 32'd0);
        goto(298, 1);
        pix("f4_bg", 12'h00F, 1'b1, 1'b1);

        // asynchronous reset mid-line
        #1 rst_n = 1'b0;
        cfg_scroll = 9'd500;
        cfg_en = 1'b0;
        #1 chk_reset("midrst");
        @(negedge clock);
        chk_reset("midrst_hold");
        rst_n = 1'b1;

        // frame A after reset is black
        pix("fa_black", 12'h000, 1'b1, 1'b1);

        // frame B: disabled, scroll 500 acts as 0
        goto(0, 0);
        chk("fcnt_after_rst", {16'd0, frame_cnt}, 32'd1);
        goto(0, 3);
        chk("addr_scr500", {18'd0, address_b}, 32'd60);
        pix("fb_dis_px", 12'h000, 1'b1, 1'b1);
        goto(700, 3);
        pix("fb_dis_hs", 12'h000, 1'b0, 1'b1);
        goto(0, VV + 1);
        pix("fb_dis_vs", 12'h000, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
